// File: rtl/iq_stream_pkg.sv
// Shared constants, packet FSM state encoding and byte-lane mapping
// for the I/Q packet stream source.
package iq_stream_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_LEN_W      = 16;

  typedef enum logic [0:0] {
    PKT_IDLE = 1'b0,
    PKT_IN   = 1'b1
  } pkt_state_e;

  localparam logic [0:0] ST_IDLE   = PKT_IDLE;
  localparam logic [0:0] ST_IN_PKT = PKT_IN;

  // Byte swap expressed as a lane mapping: output byte `lane` is taken
  // from input byte `n_lanes-1-lane`, so B3B2B1B0 becomes B0B1B2B3.
  function automatic int unsigned byte_swap_lane(input int unsigned lane,
                                                 input int unsigned n_lanes);
    return n_lanes - 1 - lane;
  endfunction

endpackage

// File: rtl/iq_sync_fifo.sv
// Synchronous FIFO with registered pointers; a write to a full FIFO is
// accepted only when a read happens on the same edge.
module iq_sync_fifo
  import iq_stream_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr_reg;
  logic [AW:0]       rd_ptr_reg;
  logic              do_wr;
  logic              do_rd;

  assign level   = wr_ptr_reg - rd_ptr_reg;
  assign full    = (level == (AW + 1)'(DEPTH));
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_rd) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/iq_packet_stream_source.sv
// Captures I/Q words (optionally byte-reversed) into a FIFO and emits them
// as Avalon-ST packets of pkt_len beats through a single output register.
module iq_packet_stream_source
  import iq_stream_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int LEN_W      = DEF_LEN_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             iq_word_in,
  input  logic                          word_valid_in,
  input  logic                          enable,
  input  logic                          swap_en,
  input  logic [LEN_W-1:0]              pkt_len,
  output logic [DATA_W-1:0]             stream_tdata,
  output logic                          stream_tvalid,
  input  logic                          stream_tready,
  output logic                          stream_tstart,
  output logic                          stream_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   overflow_cnt
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] swapped;
  logic [DATA_W-1:0] capture_word;
  logic              capture;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_rd;
  logic              fifo_wr;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              drop;

  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              out_load;
  logic              xfer;

  logic [15:0]       overflow_reg;

  logic [0:0]        state_reg, state_next;
  logic [LEN_W-1:0]  len_q_reg, len_q_next;
  logic [LEN_W-1:0]  beat_cnt_reg, beat_cnt_next;
  logic [LEN_W-1:0]  pkt_len_eff;
  logic              is_last;

  for (genvar gi = 0; gi < NB; gi++) begin : g_swap
    assign swapped[8*gi +: 8] = iq_word_in[8*byte_swap_lane(gi, NB) +: 8];
  end

  assign capture_word = swap_en ? swapped : iq_word_in;
  assign capture      = word_valid_in & enable;

  // The output register refills whenever it is empty or its beat leaves.
  assign xfer     = out_valid_reg & stream_tready;
  assign out_load = ~out_valid_reg | stream_tready;
  assign fifo_rd  = out_load & ~fifo_empty;
  assign fifo_wr  = capture & (~fifo_full | fifo_rd);
  assign drop     = capture & fifo_full & ~fifo_rd;

  iq_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fifo_wr),
    .wr_data (capture_word),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (out_load) begin
      out_valid_reg <= ~fifo_empty;
      if (!fifo_empty) begin
        out_data_reg <= fifo_rd_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg <= '0;
    end else if (drop && overflow_reg != 16'hFFFF) begin
      overflow_reg <= overflow_reg + 16'd1;
    end
  end

  assign pkt_len_eff = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
  assign is_last     = (beat_cnt_reg == len_q_reg - LEN_W'(1));

  // len_q tracks pkt_len only between packets so a packet keeps its length.
  always_comb begin
    state_next    = state_reg;
    len_q_next    = len_q_reg;
    beat_cnt_next = beat_cnt_reg;
    if (state_reg == ST_IDLE) begin
      len_q_next = pkt_len_eff;
    end
    if (xfer) begin
      beat_cnt_next = is_last ? '0 : beat_cnt_reg + LEN_W'(1);
      case (state_reg)
        ST_IDLE: begin
          if (!is_last) begin
            state_next = ST_IN_PKT;
          end
        end
        default: begin
          if (is_last) begin
            state_next = ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      len_q_reg    <= LEN_W'(1);
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      len_q_reg    <= len_q_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  assign stream_tdata  = out_data_reg;
  assign stream_tvalid = out_valid_reg;
  assign stream_tstart = out_valid_reg & (state_reg == ST_IDLE);
  assign stream_tlast  = out_valid_reg & is_last;
  assign overflow_cnt  = overflow_reg;

endmodule

// File: tb/tb_iq_packet_stream_source.sv
// Bench for iq_packet_stream_source: swap table, packet framing, overflow,
// mid-packet reset and randomized traffic against a queue-based model.
module tb_iq_packet_stream_source;

  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 16;
  localparam int LEN_W      = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] iq_word_in;
  logic        word_valid_in;
  logic        enable;
  logic        swap_en;
  logic [15:0] pkt_len;
  logic [31:0] stream_tdata;
  logic        stream_tvalid;
  logic        stream_tready;
  logic        stream_tstart;
  logic        stream_tlast;
  logic [4:0]  fifo_level;
  logic [15:0] overflow_cnt;

  always #5 clk = ~clk;

  iq_packet_stream_source #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .LEN_W      (LEN_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .iq_word_in    (iq_word_in),
    .word_valid_in (word_valid_in),
    .enable        (enable),
    .swap_en       (swap_en),
    .pkt_len       (pkt_len),
    .stream_tdata  (stream_tdata),
    .stream_tvalid (stream_tvalid),
    .stream_tready (stream_tready),
    .stream_tstart (stream_tstart),
    .stream_tlast  (stream_tlast),
    .fifo_level    (fifo_level),
    .overflow_cnt  (overflow_cnt)
  );

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] exp_q[$];
  int          beat_idx = 0;
  logic        hold_prev = 1'b0;
  logic [34:0] prev_out;

  typedef struct {
    logic        sw;
    logic [31:0] din;
    logic [31:0] dout;
  } swap_vec_t;

  swap_vec_t tbl[4];

  function automatic logic [31:0] ref_swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic int cur_len();
    return (pkt_len == 16'd0) ? 1 : int'(pkt_len);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vec_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic beat_check();
    logic [31:0] e;
    int          l;
    l = cur_len();
    if (exp_q.size() == 0) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL unexpected_beat: got %h expected no beat", stream_tdata);
    end else begin
      e = exp_q.pop_front();
      check("beat_tdata", 64'(stream_tdata), 64'(e));
      check("beat_tstart", 64'(stream_tstart), 64'((beat_idx % l) == 0));
      check("beat_tlast", 64'(stream_tlast), 64'((beat_idx % l) == l - 1));
      beat_idx++;
    end
  endtask

  // Called just after a falling edge: drive inputs, judge the pending edge, advance.
  task automatic cycle(input logic v, input logic [31:0] d, input logic sw, input logic rdy);
    word_valid_in = v;
    iq_word_in    = d;
    swap_en       = sw;
    stream_tready = rdy;
    if (hold_prev) begin
      check("hold_stable", 64'({stream_tvalid, stream_tstart, stream_tlast, stream_tdata}),
            64'(prev_out));
    end
    hold_prev = stream_tvalid && !rdy;
    prev_out  = {stream_tvalid, stream_tstart, stream_tlast, stream_tdata};
    if (stream_tvalid && rdy) beat_check();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    word_valid_in = 1'b0;
    stream_tready = 1'b0;
    enable        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    beat_idx  = 0;
    hold_prev = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tvalid"}, 64'(stream_tvalid), 64'(0));
    check({tag, "_tstart"}, 64'(stream_tstart), 64'(0));
    check({tag, "_tlast"}, 64'(stream_tlast), 64'(0));
    check({tag, "_tdata"}, 64'(stream_tdata), 64'(0));
    check({tag, "_level"}, 64'(fifo_level), 64'(0));
    check({tag, "_overflow"}, 64'(overflow_cnt), 64'(0));
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      cycle(1'b0, 32'd0, 1'b0, 1'b1);
      n++;
    end
    if (exp_q.size() > 0) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL drain_timeout: %0d beats missing, expected 0", exp_q.size());
    end
    check("drained_tvalid", 64'(stream_tvalid), 64'(0));
    check("drained_level", 64'(fifo_level), 64'(0));
  endtask

  task automatic rand_phase(input logic [15:0] len, input int n_cycles);
    logic        v;
    logic        sw;
    logic        rdy;
    logic [31:0] d;
    do_reset();
    pkt_len = len;
    for (int n = 0; n < n_cycles; n++) begin
      enable = ($urandom % 8) != 0;
      v      = (exp_q.size() < 12) && ($urandom % 2 == 0);
      d      = $urandom;
      sw     = 1'($urandom % 2);
      rdy    = 1'($urandom % 2);
      if (v && enable) exp_q.push_back(sw ? ref_swap(d) : d);
      cycle(v, d, sw, rdy);
    end
    enable = 1'b1;
    drain(100);
    check("rand_overflow", 64'(overflow_cnt), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          n;
    reset         = 1'b1;
    iq_word_in    = '0;
    word_valid_in = 1'b0;
    enable        = 1'b1;
    swap_en       = 1'b0;
    pkt_len       = 16'd1;
    stream_tready = 1'b0;
    @(negedge clk);
    do_reset();
    check_idle("reset");

    // Byte-swap table with latency check on an empty pipeline.
    tbl[0] = '{1'b1, 32'h11223344, 32'h44332211};
    tbl[1] = '{1'b0, 32'h11223344, 32'h11223344};
    tbl[2] = '{1'b1, 32'hA1B2C3D4, 32'hD4C3B2A1};
    tbl[3] = '{1'b1, 32'h00FF0000, 32'h0000FF00};
    pkt_len = 16'd1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(tbl[i].dout);
      cycle(1'b1, tbl[i].din, tbl[i].sw, 1'b1);
      check("lat_level1", 64'(fifo_level), 64'(1));
      check("lat_tvalid_k", 64'(stream_tvalid), 64'(0));
      cycle(1'b0, 32'd0, 1'b0, 1'b1);
      check("lat_tvalid_k1", 64'(stream_tvalid), 64'(1));
      cycle(1'b0, 32'd0, 1'b0, 1'b1);
      check("swap_done_tvalid", 64'(stream_tvalid), 64'(0));
    end

    // Packet framing: 8 back-to-back words, pkt_len=4.
    do_reset();
    pkt_len = 16'd4;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      exp_q.push_back(d);
      cycle(1'b1, d, 1'b0, 1'b1);
    end
    drain(50);
    check("frame_beats", 64'(beat_idx), 64'(8));

    // Overflow: 20 words against a stalled sink.
    do_reset();
    pkt_len = 16'd4;
    for (int i = 0; i < 20; i++) begin
      d = 32'hA000_0000 + 32'(i);
      if (i < 17) exp_q.push_back(d);
      cycle(1'b1, d, 1'b0, 1'b0);
    end
    check("ovf_level", 64'(fifo_level), 64'(16));
    check("ovf_count", 64'(overflow_cnt), 64'(3));
    check("ovf_tvalid", 64'(stream_tvalid), 64'(1));
    check("ovf_head", 64'(stream_tdata), 64'(32'hA000_0000));

    // Full FIFO: simultaneous write and read must not drop.
    d = 32'hB000_0000;
    exp_q.push_back(d);
    cycle(1'b1, d, 1'b0, 1'b1);
    check("fullrw_count", 64'(overflow_cnt), 64'(3));
    check("fullrw_level", 64'(fifo_level), 64'(16));
    drain(60);
    check("fullrw_count_end", 64'(overflow_cnt), 64'(3));

    // Reset in the middle of a pkt_len=4 packet, after beat 2.
    do_reset();
    pkt_len = 16'd4;
    for (int i = 0; i < 6; i++) begin
      d = 32'hC000_0000 + 32'(i);
      exp_q.push_back(d);
      cycle(1'b1, d, 1'b0, 1'b0);
    end
    n = 0;
    while (beat_idx < 3 && n < 40) begin
      cycle(1'b0, 32'd0, 1'b0, 1'b1);
      n++;
    end
    check("midpkt_beats", 64'(beat_idx), 64'(3));
    do_reset();
    pkt_len = 16'd4;
    check_idle("midpkt_reset");
    d = 32'hD00D_0001;
    exp_q.push_back(d);
    cycle(1'b1, d, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    check("post_reset_tstart", 64'(stream_tstart), 64'(1));
    check("post_reset_tlast", 64'(stream_tlast), 64'(0));
    drain(10);

    // Randomized traffic with random ready and enable.
    rand_phase(16'd1, 400);
    rand_phase(16'd3, 300);
    rand_phase(16'd0, 200);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
